// File: rtl/lsu_stage_if.sv
// rtl/lsu_stage_if.sv - request/response and data-memory bus bundle for lsu_stage
interface lsu_stage_if;
  // execute-side request
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        is_store;
  // writeback-side response
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        illegal;
  // data memory request/grant/response
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  start, addr, wdata, funct3, is_store,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ready, done, rdata, misaligned, illegal,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output start, addr, wdata, funct3, is_store,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ready, done, rdata, misaligned, illegal,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - RV32I load/store stage against a word-wide request/grant memory
module lsu_stage (
  input  logic        clk,
  input  logic        rst_n,
  lsu_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        store_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // classify the incoming request and build lane strobes / replicated store data
  always_comb begin
    req_illegal    = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                     (bus.is_store && bus.funct3[2]);
    req_misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3 == 3'b010) && (bus.addr[1:0] != 2'b00));
    req_wstrb      = 4'b0000;
    req_wdata      = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        req_wstrb = 4'b0001 << bus.addr[1:0];
        req_wdata = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        req_wstrb = bus.addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{bus.wdata[15:0]}};
      end
      default: begin
        req_wstrb = 4'b1111;
        req_wdata = bus.wdata;
      end
    endcase
    // loads never drive byte enables
    if (!bus.is_store)
      req_wstrb = 4'b0000;
  end

  // shift the addressed lane down and extend it per the latched access type
  always_comb begin
    lane     = bus.mem_rdata >> {addr_lo_q, 3'b000};
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h000000, lane[7:0]};
      3'b101:  load_ext = {16'h0000, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // control FSM; every output is a register so memory inputs never reach outputs combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      funct3_q       <= 3'b000;
      addr_lo_q      <= 2'b00;
      store_q        <= 1'b0;
      bus.ready      <= 1'b1;
      bus.done       <= 1'b0;
      bus.rdata      <= 32'h0;
      bus.misaligned <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_wstrb  <= 4'b0000;
      bus.mem_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            funct3_q      <= bus.funct3;
            addr_lo_q     <= bus.addr[1:0];
            store_q       <= bus.is_store;
            bus.ready     <= 1'b0;
            bus.mem_we    <= bus.is_store;
            bus.mem_addr  <= {bus.addr[31:2], 2'b00};
            bus.mem_wstrb <= req_wstrb;
            bus.mem_wdata <= req_wdata;
            if (req_illegal) begin
              bus.illegal <= 1'b1;
              bus.done    <= 1'b1;
              state       <= RESP;
            end else if (req_misaligned) begin
              bus.misaligned <= 1'b1;
              bus.done       <= 1'b1;
              state          <= RESP;
            end else begin
              bus.mem_req <= 1'b1;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (store_q) begin
              bus.done <= 1'b1;
              state    <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            bus.rdata <= load_ext;
            bus.done  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          bus.done       <= 1'b0;
          bus.illegal    <= 1'b0;
          bus.misaligned <= 1'b0;
          bus.ready      <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - scoreboard bench for lsu_stage
module tb_lsu_stage;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } memreq_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  resp_t   respq[$];
  memreq_t memq[$];

  lsu_stage_if bus();

  lsu_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // response monitor: pops one expected completion per DONE
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && bus.done) begin
      done_cnt++;
      if (respq.size() == 0) begin
        flag_fail("unexpected_done");
      end else begin
        r = respq.pop_front();
        chk("resp_rdata", bus.rdata, r.rdata);
        chk("resp_misaligned", {31'b0, bus.misaligned}, {31'b0, r.mis});
        chk("resp_illegal", {31'b0, bus.illegal}, {31'b0, r.ill});
      end
    end
  end

  // memory monitor: every REQ cycle must match the pending request; grant retires it
  always @(negedge clk) begin
    memreq_t m;
    if (rst_n && bus.mem_req) begin
      if (memq.size() == 0) begin
        flag_fail("unexpected_mem_req");
      end else begin
        m = memq[0];
        chk("mem_addr", bus.mem_addr, m.addr);
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, m.we});
        chk("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, m.wstrb});
        if (m.we)
          chk("mem_wdata", bus.mem_wdata, m.wdata);
        if (bus.mem_gnt)
          void'(memq.pop_front());
      end
    end
  end

  task automatic run_op(input string nm, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gw, input int rw, input logic [31:0] rword,
                        input logic [31:0] e_maddr, input logic [3:0] e_wstrb,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                        input bit e_mis, input bit e_ill, input bit repulse);
    resp_t   r;
    memreq_t m;
    bit      err;
    int      t0;
    int      explat;
    int      d0;
    err = e_mis | e_ill;
    chk({nm, "_ready_idle"}, {31'b0, bus.ready}, 32'd1);
    if (!err) begin
      m.addr = e_maddr; m.we = st; m.wstrb = e_wstrb; m.wdata = e_wdata;
      memq.push_back(m);
    end
    r.rdata = e_rdata; r.mis = e_mis; r.ill = e_ill;
    respq.push_back(r);
    d0 = done_cnt;
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    t0 = cyc;
    step();
    bus.start = 1'b0;
    chk({nm, "_ready_busy"}, {31'b0, bus.ready}, 32'd0);
    if (!err) begin
      for (int i = 0; i < gw; i++) step();
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      if (!st) begin
        for (int i = 0; i < rw; i++) begin
          if (repulse && i == 1) begin
            bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h300;
          end
          step();
          bus.start = 1'b0;
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = rword;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'h5EED_0000;
      end
    end
    for (int k = 0; k < 30 && !bus.done; k++) step();
    if (!bus.done) begin
      chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      explat = err ? 1 : (st ? 2 + gw : 3 + gw + rw);
      chk({nm, "_latency"}, cyc - t0, explat);
    end
    step();
    chk({nm, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({nm, "_done_count"}, done_cnt - d0, 32'd1);
    chk({nm, "_ready_after"}, {31'b0, bus.ready}, 32'd1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.funct3 = 3'b000; bus.is_store = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_mis", {31'b0, bus.misaligned}, 32'd0);
    chk("rst_ill", {31'b0, bus.illegal}, 32'd0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_mwdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    step();

    //      name     st f3      addr          wdata         gw rw rword         maddr         wstrb    wdata         rdata         mis ill rep
    run_op("sw_gnt3", 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 3, 0, 32'h0,        32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0, 0);
    run_op("sb_103",  1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0,        32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0000, 0, 0, 0);
    run_op("sh_102",  1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, 0, 32'h0,        32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0000, 0, 0, 0);
    run_op("lb_3",    0, 3'b000, 32'h0000_0003, 32'h0,         0, 0, 32'h80F1_7F01, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_FF80, 0, 0, 0);
    run_op("lbu_3",   0, 3'b100, 32'h0000_0003, 32'h0,         0, 1, 32'h80F1_7F01, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_0080, 0, 0, 0);
    run_op("lh_2",    0, 3'b001, 32'h0000_0002, 32'h0,         2, 0, 32'h80F1_7F01, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_80F1, 0, 0, 0);
    run_op("lhu_0",   0, 3'b101, 32'h0000_0000, 32'h0,         0, 0, 32'h80F1_7F01, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_7F01, 0, 0, 0);
    run_op("lw_0",    0, 3'b010, 32'h0000_0000, 32'h0,         1, 2, 32'h80F1_7F01, 32'h0000_0000, 4'b0000, 32'h0,        32'h80F1_7F01, 0, 0, 0);
    run_op("lw_mis",  0, 3'b010, 32'h0000_0102, 32'h0,         0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,        32'h80F1_7F01, 1, 0, 0);
    run_op("sb_ill",  1, 3'b100, 32'h0000_0100, 32'h0000_0011, 0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,        32'h80F1_7F01, 0, 1, 0);
    run_op("lh_mis",  0, 3'b001, 32'h0000_0011, 32'h0,         0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,        32'h80F1_7F01, 1, 0, 0);
    run_op("shu_pri", 1, 3'b101, 32'h0000_0001, 32'h0,         0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,        32'h80F1_7F01, 0, 1, 0);
    run_op("l011",    0, 3'b011, 32'h0000_0000, 32'h0,         0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,        32'h80F1_7F01, 0, 1, 0);
    run_op("l110",    0, 3'b110, 32'h0000_0000, 32'h0,         0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,        32'h80F1_7F01, 0, 1, 0);
    run_op("lw_rep",  0, 3'b010, 32'h0000_0200, 32'h0,         0, 4, 32'h1357_2468, 32'h0000_0200, 4'b0000, 32'h0,        32'h1357_2468, 0, 0, 1);
    run_op("sb_b2b",  1, 3'b000, 32'h0000_0201, 32'h0000_005A, 0, 0, 32'h0,        32'h0000_0200, 4'b0010, 32'h5A5A_5A5A, 32'h1357_2468, 0, 0, 0);

    // reset while a load waits for read data
    chk("rw_ready_idle", {31'b0, bus.ready}, 32'd1);
    begin
      memreq_t m;
      m.addr = 32'h40; m.we = 1'b0; m.wstrb = 4'b0000; m.wdata = 32'h0;
      memq.push_back(m);
    end
    d0 = done_cnt;
    bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h40;
    step();
    bus.start = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rw_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rw_done", {31'b0, bus.done}, 32'd0);
    chk("rw_ready", {31'b0, bus.ready}, 32'd1);
    chk("rw_rdata", bus.rdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_rvalid = 1'b0;
    step();
    step();
    chk("rw_rdata_after", bus.rdata, 32'd0);
    chk("rw_no_done", done_cnt - d0, 32'd0);
    chk("rw_ready_after", {31'b0, bus.ready}, 32'd1);
    chk("rw_mem_req_after", {31'b0, bus.mem_req}, 32'd0);

    chk("respq_empty", respq.size(), 32'd0);
    chk("memq_empty", memq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
